// File: rtl/neuron_update_scheduler.sv
// Sequences the shared LIF neuron update datapath over a presentation window and reports the winner.
// Optional LATERAL_INHIBIT_EN: in learn mode, boosts inhibitory current after the first spike of a timestep.
module neuron_update_scheduler #(
    parameter int unsigned N_NEURON = 18,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned T_STEPS  = 350,
    parameter int unsigned T_W      = 9,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_learn,
    output logic                o_init,
    input  logic                i_s_init,
    output logic                o_run,
    output logic                o_s_lern,
    output logic                o_s_infr,
    output logic signed [24:0]  o_exc_current,
    output logic signed [24:0]  o_inh_current,
    input  logic                i_spike,
    input  logic                i_valid,
    input  logic [IDX_W-1:0]    i_neuron_idx,
    output logic                o_cur_req,
    output logic [IDX_W-1:0]    o_cur_idx,
    input  logic                i_cur_valid,
    input  logic signed [24:0]  i_exc_current,
    input  logic signed [24:0]  i_inh_current,
    output logic [N_NEURON-1:0] o_spike_vec,
    output logic                o_step_done,
    output logic                o_busy,
    output logic                o_done,
    output logic [IDX_W-1:0]    o_winner,
    output logic [CNT_W-1:0]    o_winner_cnt,
    output logic                o_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_INIT_HI,
        S_INIT_LO,
        S_REQ,
        S_RUN,
        S_WAIT,
        S_STEP,
        S_ARGM,
        S_DONE
    } state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   n;
    logic [T_W-1:0]     step_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   best_idx, new_idx;
    logic [CNT_W-1:0]   best_cnt, new_cnt, cand_cnt;
    logic [CNT_W-1:0]   cnt [N_NEURON];
    logic               n_last, step_last, scan_last;
    logic signed [24:0] inh_next;

    assign n_last    = (n == IDX_W'(N_NEURON - 1));
    assign step_last = (step_cnt == T_W'(T_STEPS - 1));
    assign scan_last = (scan_idx == IDX_W'(N_NEURON - 1));
    assign o_cur_idx = n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (i_start) next_state = S_INIT;
            S_INIT:    next_state = i_s_init ? S_INIT_LO : S_INIT_HI;
            S_INIT_HI: if (i_s_init) next_state = S_INIT_LO;
            S_INIT_LO: if (!i_s_init) next_state = S_REQ;
            S_REQ:     if (i_cur_valid) next_state = S_RUN;
            S_RUN:     next_state = S_WAIT;
            S_WAIT:    if (i_valid) next_state = n_last ? S_STEP : S_REQ;
            S_STEP:    next_state = step_last ? S_ARGM : S_REQ;
            S_ARGM:    if (scan_last) next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_init      = (state == S_INIT);
        o_cur_req   = (state == S_REQ);
        o_run       = (state == S_RUN);
        o_step_done = (state == S_STEP);
        o_done      = (state == S_DONE);
        o_busy      = (state != S_IDLE);
    end

    // Running argmax: strict greater-than keeps the lowest index on ties.
    always_comb begin
        cand_cnt = cnt[scan_idx];
        new_idx  = best_idx;
        new_cnt  = best_cnt;
        if (cand_cnt > best_cnt) begin
            new_idx = scan_idx;
            new_cnt = cand_cnt;
        end
    end

`ifdef LATERAL_INHIBIT_EN
    logic               spiked;
    logic signed [25:0] inh_sum;

    assign inh_sum = {i_inh_current[24], i_inh_current} + 26'sd655360;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      spiked <= 1'b0;
        else if (state == S_IDLE && i_start)          spiked <= 1'b0;
        else if (state == S_STEP)                     spiked <= 1'b0;
        else if (state == S_WAIT && i_valid && i_spike) spiked <= 1'b1;
    end

    always_comb begin
        inh_next = i_inh_current;
        if (o_s_lern && spiked) begin
            if (inh_sum > 26'sd16777215) inh_next = 25'sh0FFFFFF;
            else                         inh_next = inh_sum[24:0];
        end
    end
`else
    always_comb begin
        inh_next = i_inh_current;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n             <= '0;
            step_cnt      <= '0;
            scan_idx      <= '0;
            best_idx      <= '0;
            best_cnt      <= '0;
            o_exc_current <= '0;
            o_inh_current <= '0;
            o_spike_vec   <= '0;
            o_err         <= 1'b0;
            o_s_lern      <= 1'b0;
            o_s_infr      <= 1'b0;
            o_winner      <= '0;
            o_winner_cnt  <= '0;
            for (int unsigned i = 0; i < N_NEURON; i++) cnt[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_s_lern    <= i_learn;
                        o_s_infr    <= ~i_learn;
                        o_spike_vec <= '0;
                        o_err       <= 1'b0;
                        step_cnt    <= '0;
                        n           <= '0;
                        for (int unsigned i = 0; i < N_NEURON; i++) cnt[i] <= '0;
                    end
                end
                S_REQ: begin
                    if (i_cur_valid) begin
                        o_exc_current <= i_exc_current;
                        o_inh_current <= inh_next;
                    end
                end
                S_WAIT: begin
                    if (i_valid) begin
                        if (i_neuron_idx != n) o_err <= 1'b1;
                        o_spike_vec[n] <= i_spike;
                        if (i_spike && cnt[n] != '1) cnt[n] <= cnt[n] + 1'b1;
                        if (!n_last) n <= n + 1'b1;
                    end
                end
                S_STEP: begin
                    step_cnt <= step_cnt + 1'b1;
                    n        <= '0;
                    scan_idx <= '0;
                    best_idx <= '0;
                    best_cnt <= '0;
                    // Last step keeps its spike vector visible through window end.
                    if (!step_last) o_spike_vec <= '0;
                end
                S_ARGM: begin
                    best_idx <= new_idx;
                    best_cnt <= new_cnt;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_last) begin
                        o_winner     <= new_idx;
                        o_winner_cnt <= new_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
